// File: rtl/req_ack_pkg.sv
// -----------------------------------------------------------------------------
// req_ack_pkg
// Shared types and defaults for the 4-phase req/ack initiator.
//   req_st_e     : initiator FSM state encoding
//   TIMEOUT_DEF  : default abort limit, in cycles spent waiting on the responder
//   GAP_DEF      : default idle cycles forced between transactions
// -----------------------------------------------------------------------------
package req_ack_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ_HI   = 2'd1,
    WAIT_REL = 2'd2,
    GAP      = 2'd3
  } req_st_e;

  localparam int TIMEOUT_DEF = 16;
  localparam int GAP_DEF     = 1;

endpackage

// File: rtl/req_ack_initiator_chk.sv
// -----------------------------------------------------------------------------
// req_ack_initiator_chk
// Bindable protocol checker for req_ack_initiator; holds no design logic.
// Ports:
//   clk, rst_n          clock and active-high reset of the initiator
//   req, ack, done, err handshake signals
//   st                  initiator FSM state
// -----------------------------------------------------------------------------
module req_ack_initiator_chk
  import req_ack_pkg::*;
(
  input logic    clk,
  input logic    rst_n,
  input logic    req,
  input logic    ack,
  input logic    done,
  input logic    err,
  input req_st_e st
);

  // req may only drop after an acknowledge or on a timeout abort.
  a_req_hold: assert property (@(posedge clk) disable iff (rst_n)
    $fell(req) |-> ($past(ack) || err))
    else $error("req_ack_initiator_chk: req released without ack");

  a_no_req_in_gap: assert property (@(posedge clk) disable iff (rst_n)
    (st == GAP) |-> !req)
    else $error("req_ack_initiator_chk: req high in GAP");

  a_done_err_excl: assert property (@(posedge clk) disable iff (rst_n)
    !(done && err))
    else $error("req_ack_initiator_chk: done and err together");

endmodule

// File: rtl/req_ack_tmo_ctr.sv
// -----------------------------------------------------------------------------
// req_ack_tmo_ctr
// Down-counting watchdog for the handshake. The count is reloaded while clr is
// high and runs while en is high. hit is raised on the MAX_CYC-th consecutive
// enabled cycle after a clear.
// Ports:
//   clk    in   clock, posedge
//   rst_n  in   asynchronous reset, active-high
//   en     in   count this cycle
//   clr    in   reload the counter
//   hit    out  limit reached (combinational, qualified by en)
// -----------------------------------------------------------------------------
module req_ack_tmo_ctr
  import req_ack_pkg::*;
#(
  parameter int MAX_CYC = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic hit
);

  localparam logic [7:0] LOAD = 8'(MAX_CYC - 1);

  logic [7:0] r_cnt;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= LOAD;
    end else if (en && (r_cnt != 8'd0)) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  assign hit = en && (r_cnt == 8'd0);

endmodule

// File: rtl/req_ack_initiator.sv
// -----------------------------------------------------------------------------
// req_ack_initiator
// Initiator side of a 4-phase req/ack handshake with a small queue of pending
// start requests and a forced idle gap between transactions.
// Build option: define REQ_ACK_INITIATOR_TIMEOUT_EN to compile in the timeout
// abort; without it err is constant 0 and the initiator waits on ack forever.
// Ports:
//   clk    in   clock, posedge
//   rst_n  in   asynchronous reset, active-high
//   start  in   one-cycle pulse, queue one transaction
//   ack    in   responder acknowledge (level)
//   req    out  request to responder (registered)
//   busy   out  FSM not idle or work queued
//   done   out  one-cycle pulse, transaction completed
//   err    out  one-cycle pulse, transaction aborted by timeout
//   pend   out  queued, unstarted transactions
//   full   out  pend at capacity (further starts are dropped)
//
// state    | meaning
// ---------+--------------------------------------------------
// IDLE     | nothing in flight; launches when work is queued
// REQ_HI   | req driven high, waiting for ack=1
// WAIT_REL | req released, waiting for ack=0
// GAP      | enforced idle time before the next launch
// -----------------------------------------------------------------------------
module req_ack_initiator
  import req_ack_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_DEF,
  parameter int GAP_CYC     = GAP_DEF,
  parameter int PEND_W      = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              ack,
  output logic              req,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [PEND_W-1:0] pend,
  output logic              full
);

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255 || GAP_CYC < 0 || GAP_CYC > 15 || PEND_W < 1)
  begin : g_bad_param
    $error("req_ack_initiator: parameter out of range");
  end

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [3:0]        GAP_LOAD = 4'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);
  // Where a finished or aborted transaction goes next.
  localparam req_st_e           POST_ST  = (GAP_CYC > 0) ? GAP : IDLE;

  req_st_e           r_st;
  req_st_e           w_st_nxt;
  logic [PEND_W-1:0] r_pend;
  logic [3:0]        r_gap;
  logic              r_req;
  logic              r_done;
  logic              r_err;
  logic              w_req_nxt;
  logic              w_done_nxt;
  logic              w_err_nxt;
  logic              w_full;
  logic              w_accept;
  logic              w_launch;
  logic              w_tmo_hit;

  assign w_full   = (r_pend == PEND_MAX);
  assign w_accept = start && !w_full;
  // A start arriving while idle with an empty queue launches directly.
  assign w_launch = (r_st == IDLE) && ((r_pend != '0) || w_accept);

`ifdef REQ_ACK_INITIATOR_TIMEOUT_EN
  logic w_tmo_en;

  // Spans both REQ_HI and WAIT_REL: the limit covers the whole handshake.
  assign w_tmo_en = (r_st == REQ_HI) || (r_st == WAIT_REL);

  req_ack_tmo_ctr #(
    .MAX_CYC (TIMEOUT_CYC)
  ) u_tmo (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_tmo_en),
    .clr   (!w_tmo_en),
    .hit   (w_tmo_hit)
  );
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_st   <= IDLE;
      r_req  <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_st   <= w_st_nxt;
      r_req  <= w_req_nxt;
      r_done <= w_done_nxt;
      r_err  <= w_err_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_pend <= '0;
      r_gap  <= '0;
    end else begin
      case ({w_accept, w_launch})
        2'b10:   r_pend <= r_pend + 1'b1;
        2'b01:   r_pend <= r_pend - 1'b1;
        default: r_pend <= r_pend;
      endcase
      if ((w_st_nxt == GAP) && (r_st != GAP)) begin
        r_gap <= GAP_LOAD;
      end else if ((r_st == GAP) && (r_gap != 4'd0)) begin
        r_gap <= r_gap - 4'd1;
      end
    end
  end

  always_comb begin
    w_st_nxt = r_st;
    case (r_st)
      IDLE:     if (w_launch) w_st_nxt = REQ_HI;
      REQ_HI:   if (ack) w_st_nxt = WAIT_REL;
                else if (w_tmo_hit) w_st_nxt = POST_ST;
      WAIT_REL: if (!ack || w_tmo_hit) w_st_nxt = POST_ST;
      GAP:      if (r_gap == 4'd0) w_st_nxt = IDLE;
      default:  w_st_nxt = IDLE;
    endcase
  end

  // A normal completion outranks a coincident timeout, so done and err
  // can never fire together.
  always_comb begin
    w_req_nxt  = (w_st_nxt == REQ_HI);
    w_done_nxt = (r_st == WAIT_REL) && !ack;
    w_err_nxt  = w_tmo_hit && (((r_st == REQ_HI) && !ack) || ((r_st == WAIT_REL) && ack));
  end

  assign req  = r_req;
  assign done = r_done;
  assign err  = r_err;
  assign pend = r_pend;
  assign full = w_full;
  assign busy = (r_st != IDLE) || (r_pend != '0);

endmodule

// File: tb/tb_req_ack_initiator.sv
// Directed bench for req_ack_initiator. Timeout checks are selected by
// REQ_ACK_INITIATOR_TIMEOUT_EN, matching the build of the design.
module tb_req_ack_initiator;

  localparam int TB_TMO = 12;
  localparam int TB_GAP = 1;
  localparam int PW     = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          ack;
  logic          req;
  logic          busy;
  logic          done;
  logic          err;
  logic [PW-1:0] pend;
  logic          full;

  int n_tests = 0;
  int n_fail  = 0;

  req_ack_initiator #(
    .TIMEOUT_CYC (TB_TMO),
    .GAP_CYC     (TB_GAP),
    .PEND_W      (PW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .ack   (ack),
    .req   (req),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .pend  (pend),
    .full  (full)
  );

  bind req_ack_initiator req_ack_initiator_chk u_chk (
    .clk(clk), .rst_n(rst_n), .req(req), .ack(ack), .done(done), .err(err), .st(r_st)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    start = 1'b0;
    ack   = 1'b0;
    rst_n = 1'b1;
    tick;
    tick;
    rst_n = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    start = 1'b0;
    ack   = 1'b0;
    #12;
    n_tests++;
    if ({req, done, err, busy, full, pend} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_state: got %b want 00000000", {req, done, err, busy, full, pend});
    end
    start = 1'b1;
    tick;
    tick;
    start = 1'b0;
    n_tests++;
    if ({req, busy, pend} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ignores_start: got %b want 00000", {req, busy, pend});
    end
    rst_n = 1'b0;
  endtask

  task automatic test_single;
    int hi;
    start = 1'b1;
    tick;
    start = 1'b0;
    n_tests++;
    if ({req, busy, pend} !== {1'b1, 1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL single_launch: got %b want 11000", {req, busy, pend});
    end
    hi = 1;
    repeat (3) begin
      tick;
      if (req) hi++;
    end
    ack = 1'b1;
    tick;
    if (req) hi++;
    n_tests++;
    if (hi !== 4) begin
      n_fail++;
      $display("FAIL single_req_width: got %0d want 4", hi);
    end
    tick;
    ack = 1'b0;
    tick;
    n_tests++;
    if ({done, err, busy} !== 3'b101) begin
      n_fail++;
      $display("FAIL single_done: got %b want 101", {done, err, busy});
    end
    tick;
    n_tests++;
    if ({done, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL single_back_idle: got %b want 00", {done, busy});
    end
  endtask

  task automatic test_back_to_back;
    int   n_req = 0, n_done = 0, n_err = 0, pmax = 0, low = 0, min_low = 1000;
    logic prev_req = 1'b0;
    bit   seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      start = (c < 3);
      ack   = req;
      tick;
      if (req && !prev_req) begin
        n_req++;
        if (seen && (low < min_low)) min_low = low;
        seen = 1'b1;
      end
      if (req) low = 0;
      else low++;
      if (done) n_done++;
      if (err) n_err++;
      if (int'(pend) > pmax) pmax = int'(pend);
      prev_req = req;
    end
    start = 1'b0;
    n_tests++;
    if (n_req !== 3) begin
      n_fail++;
      $display("FAIL b2b_req_count: got %0d want 3", n_req);
    end
    n_tests++;
    if (n_done !== 3 || n_err !== 0) begin
      n_fail++;
      $display("FAIL b2b_done_err: got done=%0d err=%0d want done=3 err=0", n_done, n_err);
    end
    n_tests++;
    if (pmax !== 2) begin
      n_fail++;
      $display("FAIL b2b_pend_peak: got %0d want 2", pmax);
    end
    // release cycle + one gap cycle + one idle cycle between req pulses
    n_tests++;
    if (min_low !== 3) begin
      n_fail++;
      $display("FAIL b2b_idle_between: got %0d want 3", min_low);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_ack_idle;
    int bad = 0;
    ack = 1'b1;
    repeat (5) begin
      tick;
      if (req || busy || done || err) bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL ack_idle_ignored: got %0d bad cycles want 0", bad);
    end
    start = 1'b1;
    tick;
    start = 1'b0;
    n_tests++;
    if (req !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_idle_req: got %b want 1", req);
    end
    tick;
    n_tests++;
    if ({req, busy, done} !== 3'b010) begin
      n_fail++;
      $display("FAIL ack_idle_wait_rel: got %b want 010", {req, busy, done});
    end
    ack = 1'b0;
    tick;
    n_tests++;
    if ({done, err} !== 2'b10) begin
      n_fail++;
      $display("FAIL ack_idle_done: got %b want 10", {done, err});
    end
    tick;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_idle_end_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_queue_full;
    int early_err = 0;
    ack = 1'b0;
    // The first start launches directly, so nine starts are needed to
    // fill seven queue slots and then have one dropped.
    for (int c = 0; c < 9; c++) begin
      start = 1'b1;
      tick;
      if (err) early_err++;
      if (c == 6) begin
        n_tests++;
        if ({pend, full} !== {3'd6, 1'b0}) begin
          n_fail++;
          $display("FAIL queue_six: got pend=%0d full=%b want pend=6 full=0", pend, full);
        end
      end
      if (c == 7) begin
        n_tests++;
        if ({pend, full} !== {3'd7, 1'b1}) begin
          n_fail++;
          $display("FAIL queue_full: got pend=%0d full=%b want pend=7 full=1", pend, full);
        end
      end
    end
    start = 1'b0;
    n_tests++;
    if ({req, pend, full, early_err[0]} !== {1'b1, 3'd7, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL queue_drop: got req=%b pend=%0d full=%b err=%0d want req=1 pend=7 full=1 err=0",
               req, pend, full, early_err);
    end
`ifdef REQ_ACK_INITIATOR_TIMEOUT_EN
    begin
      int first_err = -1, last_err = -1, n_err = 0, bad_int = 0, n_done = 0;
      for (int c = 9; c <= 44; c++) begin
        tick;
        if (err) begin
          n_err++;
          if (last_err >= 0 && (c - last_err) != (TB_TMO + TB_GAP + 1)) bad_int++;
          if (first_err < 0) first_err = c;
          last_err = c;
        end
        if (done) n_done++;
      end
      n_tests++;
      if (first_err !== 12) begin
        n_fail++;
        $display("FAIL tmo_first_err: got cycle %0d want 12", first_err);
      end
      n_tests++;
      if (n_err !== 3 || bad_int !== 0 || n_done !== 0) begin
        n_fail++;
        $display("FAIL tmo_period: got err=%0d bad_int=%0d done=%0d want err=3 bad_int=0 done=0",
                 n_err, bad_int, n_done);
      end
      n_tests++;
      if ({pend, req} !== {3'd4, 1'b1}) begin
        n_fail++;
        $display("FAIL tmo_pend_drain: got pend=%0d req=%b want pend=4 req=1", pend, req);
      end
    end
`else
    begin
      int bad = 0;
      repeat (100) begin
        tick;
        if (!req || err || !busy || done) bad++;
      end
      n_tests++;
      if (bad !== 0) begin
        n_fail++;
        $display("FAIL hold_no_timeout: got %0d bad cycles want 0", bad);
      end
      n_tests++;
      if (pend !== 3'd7) begin
        n_fail++;
        $display("FAIL hold_pend: got %0d want 7", pend);
      end
    end
`endif
  endtask

  task automatic test_reset_mid;
    int nd = 0;
    start = 1'b1;
    tick;
    ack = 1'b1;
    tick;
    tick;
    start = 1'b0;
    n_tests++;
    if ({req, busy, pend} !== {1'b0, 1'b1, 3'd2}) begin
      n_fail++;
      $display("FAIL mid_wait_rel: got req=%b busy=%b pend=%0d want req=0 busy=1 pend=2", req, busy, pend);
    end
    #2;
    rst_n = 1'b1;
    #1;
    n_tests++;
    if ({req, busy, done, err, full, pend} !== 8'b0) begin
      n_fail++;
      $display("FAIL mid_reset_async: got %b want 00000000", {req, busy, done, err, full, pend});
    end
    ack = 1'b0;
    repeat (3) begin
      tick;
      if (done || err) nd++;
    end
    rst_n = 1'b0;
    n_tests++;
    if (nd !== 0) begin
      n_fail++;
      $display("FAIL mid_reset_no_done: got %0d pulses want 0", nd);
    end
    start = 1'b1;
    tick;
    start = 1'b0;
    n_tests++;
    if ({req, pend} !== {1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL first_start_after_reset: got req=%b pend=%0d want req=1 pend=0", req, pend);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    do_reset;
    test_back_to_back;
    do_reset;
    test_ack_idle;
    do_reset;
    test_queue_full;
    do_reset;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
